trace_scheduler: RTL and testbench

//  Frame-level sequencer for the ray tracer. Opens a trace window at a fixed VGA

---
 rtl/trace_scheduler_if.sv | 37 +++
 rtl/trace_scheduler.sv | 151 +++++++++++++++
 tb/tb_trace_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_scheduler_if.sv
// Vector-source and tracer-facing signal bundle for the trace scheduler.
interface trace_scheduler_if #(
    parameter int unsigned FW = 24
);
    logic          vec_valid;
    logic          vec_ready_c;
    logic [FW-1:0] vec_px;
    logic [FW-1:0] vec_py;
    logic [FW-1:0] vec_fx;
    logic [FW-1:0] vec_fy;
    logic [FW-1:0] vec_vx;
    logic [FW-1:0] vec_vy;

    logic [FW-1:0] tr_px;
    logic [FW-1:0] tr_py;
    logic [FW-1:0] tr_fx;
    logic [FW-1:0] tr_fy;
    logic [FW-1:0] tr_vx;
    logic [FW-1:0] tr_vy;
    logic          tr_enable;
    logic          tr_store;
    logic [9:0]    tr_column;

    modport slave (
        input  vec_valid, vec_px, vec_py, vec_fx, vec_fy, vec_vx, vec_vy,
        input  tr_store, tr_column,
        output vec_ready_c,
        output tr_px, tr_py, tr_fx, tr_fy, tr_vx, tr_vy, tr_enable
    );

    modport master (
        output vec_valid, vec_px, vec_py, vec_fx, vec_fy, vec_vx, vec_vy,
        output tr_store, tr_column,
        input  vec_ready_c,
        input  tr_px, tr_py, tr_fx, tr_fy, tr_vx, tr_vy, tr_enable
    );
endinterface

// File: rtl/trace_scheduler.sv
// Frame-level sequencer for the ray tracer: opens/closes the trace window, freezes a
// coherent vector snapshot, drives tracer enable and reports completion/overrun.
module trace_scheduler #(
    parameter int unsigned FW         = 24,
    parameter int unsigned START_LINE = 480,
    parameter int unsigned LAST_COL   = 575,
    parameter int unsigned CW         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        hpos_i,
    input  logic [9:0]        vpos_i,
    input  logic              overrun_clr_i,
    output logic [10:0]       frame_num_o,
    output logic              frame_done_o,
    output logic [CW-1:0]     last_cycles_o,
    output logic              overrun_o,
    trace_scheduler_if.slave  bus
);
    localparam int unsigned PW  = 10;
    localparam int unsigned FNW = 11;

    typedef struct packed {
        logic [FW-1:0] px;
        logic [FW-1:0] py;
        logic [FW-1:0] fx;
        logic [FW-1:0] fy;
        logic [FW-1:0] vx;
        logic [FW-1:0] vy;
    } vec_t;

    typedef enum logic [1:0] {IDLE, ARM, TRACE, HOLD} state_e;

    state_e         state_q, state_d;
    vec_t           pend_q, pend_d;
    vec_t           snap_q, snap_d;
    vec_t           vec_in;
    logic           dirty_q, dirty_d;
    logic [FNW-1:0] frame_q, frame_d;
    logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [CW-1:0]  lc_q, lc_d;
    logic           en_q, en_d;
    logic           done_q, done_d;
    logic           ovr_q, ovr_d, ovr_set;
    logic           win_open, win_close, latch, last_store;

    assign win_open   = (vpos_i == PW'(START_LINE)) && (hpos_i == '0);
    assign win_close  = (vpos_i == '0) && (hpos_i == '0);
    assign latch      = (state_q == IDLE) && win_open;
    assign last_store = bus.tr_store && (bus.tr_column == PW'(LAST_COL));
    assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
    assign vec_in     = {bus.vec_px, bus.vec_py, bus.vec_fx,
                         bus.vec_fy, bus.vec_vx, bus.vec_vy};

    // The pending register is blocked only in the cycle it is copied into the snapshot
    assign bus.vec_ready_c = !latch;

    // Next-state and register updates
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        dirty_d = dirty_q;
        snap_d  = snap_q;
        frame_d = frame_q;
        cnt_d   = cnt_q;
        lc_d    = lc_q;
        done_d  = 1'b0;
        ovr_set = 1'b0;

        if (bus.vec_valid && !latch) begin
            pend_d  = vec_in;
            dirty_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (win_open) begin
                    if (dirty_q) begin
                        snap_d  = pend_q;
                        dirty_d = 1'b0;
                    end
                    frame_d = frame_q + FNW'(1);
                    cnt_d   = '0;
                    state_d = ARM;
                end
            end
            ARM: state_d = TRACE;
            TRACE: begin
                cnt_d = cnt_inc;
                // Completion beats a coincident window close; HOLD exits on the next close
                if (last_store) begin
                    lc_d    = cnt_inc;
                    done_d  = 1'b1;
                    state_d = HOLD;
                end else if (win_close) begin
                    ovr_set = 1'b1;
                    lc_d    = '1;
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (win_close) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ovr_d = ovr_set || (ovr_q && !overrun_clr_i);
        en_d  = (state_d == TRACE) || (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
            dirty_q <= 1'b0;
            snap_q  <= '0;
            frame_q <= '0;
            cnt_q   <= '0;
            lc_q    <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            dirty_q <= dirty_d;
            snap_q  <= snap_d;
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
            lc_q    <= lc_d;
            en_q    <= en_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.tr_enable = en_q;
    assign bus.tr_px     = snap_q.px;
    assign bus.tr_py     = snap_q.py;
    assign bus.tr_fx     = snap_q.fx;
    assign bus.tr_fy     = snap_q.fy;
    assign bus.tr_vx     = snap_q.vx;
    assign bus.tr_vy     = snap_q.vy;
    assign frame_num_o   = frame_q;
    assign frame_done_o  = done_q;
    assign last_cycles_o = lc_q;
    assign overrun_o     = ovr_q;

endmodule

// File: tb/tb_trace_scheduler.sv
// Bench for trace_scheduler: directed vector table, long-trace/overrun/reset/wrap
// sequences, and randomized traffic against a window-level reference model.
module tb_trace_scheduler;
    localparam int unsigned FW = 24;
    localparam int unsigned CW = 16;

    logic          clk;
    logic          reset;
    logic [9:0]    hpos, vpos;
    logic          overrun_clr;
    logic          vv, st;
    logic [9:0]    col;
    logic [FW-1:0] vin [6];
    logic [FW-1:0] tro [6];
    logic [10:0]   frame_num;
    logic          frame_done;
    logic [CW-1:0] last_cycles;
    logic          overrun;

    int n_checks = 0;
    int n_errors = 0;
    bit model_on = 1'b0;

    trace_scheduler_if #(.FW(FW)) bus ();

    trace_scheduler #(.FW(FW), .START_LINE(480), .LAST_COL(575), .CW(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .hpos_i        (hpos),
        .vpos_i        (vpos),
        .overrun_clr_i (overrun_clr),
        .frame_num_o   (frame_num),
        .frame_done_o  (frame_done),
        .last_cycles_o (last_cycles),
        .overrun_o     (overrun),
        .bus           (bus)
    );

    assign bus.vec_valid = vv;
    assign bus.tr_store  = st;
    assign bus.tr_column = col;
    assign bus.vec_px    = vin[0];
    assign bus.vec_py    = vin[1];
    assign bus.vec_fx    = vin[2];
    assign bus.vec_fy    = vin[3];
    assign bus.vec_vx    = vin[4];
    assign bus.vec_vy    = vin[5];
    assign tro[0]        = bus.tr_px;
    assign tro[1]        = bus.tr_py;
    assign tro[2]        = bus.tr_fx;
    assign tro[3]        = bus.tr_fy;
    assign tro[4]        = bus.tr_vx;
    assign tro[5]        = bus.tr_vy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the window as "active since latch edge" plus elapsed cycles
    bit            m_active   = 1'b0;
    bit            m_finished = 1'b0;
    bit            m_dirty    = 1'b0;
    bit            m_done     = 1'b0;
    bit            m_ovr      = 1'b0;
    int            m_elapsed  = 0;
    logic [10:0]   m_fn       = '0;
    logic [15:0]   m_lc       = '0;
    logic [FW-1:0] m_pend [6];
    logic [FW-1:0] m_snap [6];

    function automatic logic m_ready();
        return !(!m_active && (vpos == 10'd480) && (hpos == 10'd0));
    endfunction

    always @(posedge clk) begin
        logic op, cl, take, set_o;
        op    = (vpos == 10'd480) && (hpos == 10'd0);
        cl    = (vpos == 10'd0) && (hpos == 10'd0);
        take  = vv && m_ready();
        set_o = 1'b0;
        if (reset) begin
            m_active = 0; m_finished = 0; m_dirty = 0; m_done = 0; m_ovr = 0;
            m_elapsed = 0; m_fn = '0; m_lc = '0;
            for (int k = 0; k < 6; k++) begin
                m_pend[k] = '0;
                m_snap[k] = '0;
            end
        end else begin
            m_done = 0;
            if (!m_active) begin
                if (op) begin
                    m_active = 1; m_finished = 0; m_elapsed = 0;
                    m_fn = m_fn + 11'd1;
                    if (m_dirty) for (int k = 0; k < 6; k++) m_snap[k] = m_pend[k];
                    m_dirty = 0;
                end
            end else begin
                if (m_elapsed >= 1 && !m_finished && st && col == 10'd575) begin
                    m_finished = 1;
                    m_done     = 1;
                    m_lc       = (m_elapsed > 65535) ? 16'hFFFF : 16'(m_elapsed);
                end else if (m_elapsed >= 1 && cl) begin
                    m_active = 0;
                    if (!m_finished) begin
                        set_o = 1;
                        m_lc  = 16'hFFFF;
                    end
                end
                if (m_elapsed < 32'h4000_0000) m_elapsed++;
            end
            if (take) begin
                for (int k = 0; k < 6; k++) m_pend[k] = vin[k];
                m_dirty = 1;
            end
            if (set_o) m_ovr = 1;
            else if (overrun_clr) m_ovr = 0;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("m_enable", 32'(bus.tr_enable), 32'(m_active && (m_elapsed >= 1)));
            chk("m_frame_num", 32'(frame_num), 32'(m_fn));
            chk("m_frame_done", 32'(frame_done), 32'(m_done));
            chk("m_last_cycles", 32'(last_cycles), 32'(m_lc));
            chk("m_overrun", 32'(overrun), 32'(m_ovr));
            for (int k = 0; k < 6; k++)
                chk($sformatf("m_tr%0d", k), 32'(tro[k]), 32'(m_snap[k]));
        end
    end

    task automatic set_in(input logic [9:0] hp, input logic [9:0] vp, input logic v,
                          input logic [FW-1:0] px, input logic s, input logic [9:0] c,
                          input logic cl);
        hpos = hp; vpos = vp; vv = v; st = s; col = c; overrun_clr = cl;
        for (int k = 0; k < 6; k++) vin[k] = px + FW'(k * 32'h0001_0101);
    endtask

    task automatic idle();
        set_in(10'd5, 10'd100, 1'b0, '0, 1'b0, 10'd0, 1'b0);
    endtask

    task automatic pre();
        #1;
        if (model_on) chk("m_vec_ready", 32'(bus.vec_ready_c), 32'(m_ready()));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic step();
        pre();
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        step();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [9:0]    hp;
        logic [9:0]    vp;
        logic          v;
        logic [FW-1:0] px;
        logic          s;
        logic [9:0]    c;
        logic          cl;
        logic          rdy;
        logic          en;
        logic [10:0]   fn;
        logic [FW-1:0] tpx;
        logic          done;
        logic          ovr;
        logic [15:0]   lc;
    } vrec_t;

    vrec_t tbl [17];

    initial begin
        tbl[0]  = '{10'd0, 10'd480, 1'b0, 24'h0,      1'b0, 10'd0,   1'b0, 1'b0, 1'b0, 11'd1, 24'h0,      1'b0, 1'b0, 16'h0};
        tbl[1]  = '{10'd1, 10'd480, 1'b0, 24'h0,      1'b0, 10'd0,   1'b0, 1'b1, 1'b1, 11'd1, 24'h0,      1'b0, 1'b0, 16'h0};
        tbl[2]  = '{10'd2, 10'd480, 1'b0, 24'h0,      1'b0, 10'd0,   1'b0, 1'b1, 1'b1, 11'd1, 24'h0,      1'b0, 1'b0, 16'h0};
        tbl[3]  = '{10'd0, 10'd0,   1'b0, 24'h0,      1'b0, 10'd0,   1'b0, 1'b1, 1'b0, 11'd1, 24'h0,      1'b0, 1'b1, 16'hFFFF};
        tbl[4]  = '{10'd7, 10'd9,   1'b0, 24'h0,      1'b0, 10'd0,   1'b1, 1'b1, 1'b0, 11'd1, 24'h0,      1'b0, 1'b0, 16'hFFFF};
        tbl[5]  = '{10'd10,10'd200, 1'b1, 24'h018000, 1'b0, 10'd0,   1'b0, 1'b1, 1'b0, 11'd1, 24'h0,      1'b0, 1'b0, 16'hFFFF};
        tbl[6]  = '{10'd0, 10'd480, 1'b0, 24'h0,      1'b0, 10'd0,   1'b0, 1'b0, 1'b0, 11'd2, 24'h018000, 1'b0, 1'b0, 16'hFFFF};
        tbl[7]  = '{10'd4, 10'd480, 1'b1, 24'hAAAAAA, 1'b0, 10'd0,   1'b0, 1'b1, 1'b1, 11'd2, 24'h018000, 1'b0, 1'b0, 16'hFFFF};
        tbl[8]  = '{10'd3, 10'd480, 1'b0, 24'h0,      1'b0, 10'd0,   1'b0, 1'b1, 1'b1, 11'd2, 24'h018000, 1'b0, 1'b0, 16'hFFFF};
        tbl[9]  = '{10'd9, 10'd481, 1'b0, 24'h0,      1'b1, 10'd575, 1'b0, 1'b1, 1'b1, 11'd2, 24'h018000, 1'b1, 1'b0, 16'd2};
        tbl[10] = '{10'd9, 10'd482, 1'b0, 24'h0,      1'b1, 10'd574, 1'b0, 1'b1, 1'b1, 11'd2, 24'h018000, 1'b0, 1'b0, 16'd2};
        tbl[11] = '{10'd0, 10'd480, 1'b0, 24'h0,      1'b0, 10'd0,   1'b0, 1'b1, 1'b1, 11'd2, 24'h018000, 1'b0, 1'b0, 16'd2};
        tbl[12] = '{10'd0, 10'd0,   1'b0, 24'h0,      1'b0, 10'd0,   1'b0, 1'b1, 1'b0, 11'd2, 24'h018000, 1'b0, 1'b0, 16'd2};
        tbl[13] = '{10'd0, 10'd480, 1'b1, 24'h000555, 1'b0, 10'd0,   1'b0, 1'b0, 1'b0, 11'd3, 24'hAAAAAA, 1'b0, 1'b0, 16'd2};
        tbl[14] = '{10'd1, 10'd480, 1'b1, 24'h000555, 1'b0, 10'd0,   1'b0, 1'b1, 1'b1, 11'd3, 24'hAAAAAA, 1'b0, 1'b0, 16'd2};
        tbl[15] = '{10'd0, 10'd0,   1'b0, 24'h0,      1'b0, 10'd0,   1'b1, 1'b1, 1'b0, 11'd3, 24'hAAAAAA, 1'b0, 1'b1, 16'hFFFF};
        tbl[16] = '{10'd0, 10'd480, 1'b0, 24'h0,      1'b0, 10'd0,   1'b0, 1'b0, 1'b0, 11'd4, 24'h000555, 1'b0, 1'b1, 16'hFFFF};

        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
        chk("rst_enable", 32'(bus.tr_enable), 32'd0);
        chk("rst_frame_num", 32'(frame_num), 32'd0);
        chk("rst_last_cycles", 32'(last_cycles), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_tr_px", 32'(bus.tr_px), 32'd0);
        model_on = 1'b1;

        // Directed cycle table: first window, snapshot freeze, LATCH-cycle backpressure
        for (int i = 0; i < 17; i++) begin
            set_in(tbl[i].hp, tbl[i].vp, tbl[i].v, tbl[i].px, tbl[i].s, tbl[i].c, tbl[i].cl);
            pre();
            chk($sformatf("t%0d_vec_ready", i), 32'(bus.vec_ready_c), 32'(tbl[i].rdy));
            tick();
            chk($sformatf("t%0d_enable", i), 32'(bus.tr_enable), 32'(tbl[i].en));
            chk($sformatf("t%0d_frame_num", i), 32'(frame_num), 32'(tbl[i].fn));
            chk($sformatf("t%0d_tr_px", i), 32'(bus.tr_px), 32'(tbl[i].tpx));
            chk($sformatf("t%0d_frame_done", i), 32'(frame_done), 32'(tbl[i].done));
            chk($sformatf("t%0d_overrun", i), 32'(overrun), 32'(tbl[i].ovr));
            chk($sformatf("t%0d_last_cycles", i), 32'(last_cycles), 32'(tbl[i].lc));
        end

        // Long trace: store of the last column in the 9000th TRACE cycle
        do_reset();
        set_in(10'd0, 10'd480, 1'b0, '0, 1'b0, 10'd0, 1'b0);
        step();
        idle();
        step();
        chk("long_enable_start", 32'(bus.tr_enable), 32'd1);
        for (int i = 1; i < 9000; i++) begin
            set_in(10'(1 + (i % 700)), 10'(1 + (i % 400)), 1'b0, '0, 1'b1, 10'(i % 575), 1'b0);
            step();
        end
        chk("long_done_early", 32'(frame_done), 32'd0);
        set_in(10'd17, 10'd300, 1'b0, '0, 1'b1, 10'd575, 1'b0);
        step();
        chk("long_frame_done", 32'(frame_done), 32'd1);
        chk("long_last_cycles", 32'(last_cycles), 32'd9000);
        idle();
        step();
        chk("long_done_pulse", 32'(frame_done), 32'd0);
        repeat (4) step();
        chk("long_hold_enable", 32'(bus.tr_enable), 32'd1);
        set_in(10'd0, 10'd0, 1'b0, '0, 1'b0, 10'd0, 1'b0);
        step();
        chk("long_close_enable", 32'(bus.tr_enable), 32'd0);
        chk("long_no_overrun", 32'(overrun), 32'd0);
        chk("long_lc_kept", 32'(last_cycles), 32'd9000);

        // Reset in the middle of TRACE loses pending data and drops enable
        do_reset();
        set_in(10'd0, 10'd480, 1'b0, '0, 1'b0, 10'd0, 1'b0);
        step();
        idle();
        step();
        set_in(10'd6, 10'd100, 1'b1, 24'h123456, 1'b0, 10'd0, 1'b0);
        step();
        idle();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_enable", 32'(bus.tr_enable), 32'd0);
        chk("mid_rst_frame_num", 32'(frame_num), 32'd0);
        chk("mid_rst_done", 32'(frame_done), 32'd0);
        chk("mid_rst_lc", 32'(last_cycles), 32'd0);
        set_in(10'd0, 10'd480, 1'b0, '0, 1'b0, 10'd0, 1'b0);
        step();
        chk("mid_rst_pending_lost", 32'(bus.tr_px), 32'd0);
        chk("mid_rst_fn_after", 32'(frame_num), 32'd1);

        // Frame number wraps after 2048 windows
        do_reset();
        for (int f = 1; f <= 2048; f++) begin
            set_in(10'd0, 10'd480, 1'b0, '0, 1'b0, 10'd0, 1'b0);
            step();
            if (f == 2047) chk("wrap_fn_2047", 32'(frame_num), 32'd2047);
            if (f == 2048) chk("wrap_fn_0", 32'(frame_num), 32'd0);
            idle();
            step();
            set_in(10'd0, 10'd0, 1'b0, '0, 1'b0, 10'd0, 1'b0);
            step();
        end

        // Randomized traffic checked every cycle by the reference model
        do_reset();
        for (int i = 0; i < 20000; i++) begin
            int r;
            logic [9:0] hp, vp;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                hp = 10'd0; vp = 10'd480;
            end else if (r < 5) begin
                hp = 10'd0; vp = 10'd0;
            end else begin
                hp = 10'($urandom_range(1, 799));
                vp = 10'($urandom_range(0, 524));
            end
            set_in(hp, vp, $urandom_range(0, 3) == 0, FW'($urandom),
                   $urandom_range(0, 3) == 0,
                   ($urandom_range(0, 19) == 0) ? 10'd575 : 10'($urandom_range(0, 639)),
                   $urandom_range(0, 29) == 0);
            reset = ($urandom_range(0, 1999) == 0);
            step();
        end
        reset = 1'b0;
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
